// File: rtl/intr_pkg.sv
// ============================================================================
//  Module      : intr_pkg
//  Description : Shared types and constants for the multi-source interrupt
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package intr_pkg;

    // Widest priority a build may select; narrower PRIO_W zero-extends.
    localparam int PRIO_MAX_W = 16;

    // Handlers are halfword aligned, so bit 0 of every stored vector is zero.
    localparam logic [31:0] VEC_ALIGN_MASK = 32'hFFFF_FFFE;

    typedef enum logic [1:0] {
        INTR_IDLE    = 2'd0,
        INTR_REQ     = 2'd1,
        INTR_SERVICE = 2'd2
    } intr_state_t;

    typedef struct packed {
        logic                  en;
        logic [PRIO_MAX_W-1:0] prio;
        logic [31:0]           vector;
    } intr_cfg_t;

endpackage

`default_nettype wire

// File: rtl/intr_arbiter.sv
// ============================================================================
//  Module      : intr_arbiter
//  Description : Combinational priority arbiter; highest priority wins,
//                ties resolved towards the lowest channel index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_arbiter #(
    parameter  int NUM_SRC = 8,
    parameter  int PRIO_W  = 3,
    localparam int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]             req,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
    output logic                           valid,
    output logic [ID_W-1:0]                win_id
);

    logic [PRIO_W-1:0] best_prio;
    logic [ID_W-1:0]   best_id;
    logic              found;

    // Strict greater-than keeps the earliest index on equal priority.
    always_comb begin
        best_prio = '0;
        best_id   = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i] && (!found || (prio[i] > best_prio))) begin
                found     = 1'b1;
                best_prio = prio[i];
                best_id   = ID_W'(i);
            end
        end
    end

    assign valid  = found;
    assign win_id = best_id;

endmodule

`default_nettype wire

// File: rtl/intr_ctrl.sv
// ============================================================================
//  Module      : intr_ctrl
//  Description : Multi-source interrupt controller feeding a single-request
//                cpu interrupt port; one request in flight, no nesting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_ctrl
    import intr_pkg::*;
#(
    parameter  int                 NUM_SRC     = 8,
    parameter  int                 PRIO_W      = 3,
    parameter  logic [NUM_SRC-1:0] EDGE_MASK   = '0,
    parameter  int                 SYNC_STAGES = 2,
    localparam int                 ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_we,
    input  logic [ID_W-1:0]    cfg_sel,
    input  logic               cfg_en,
    input  logic [PRIO_W-1:0]  cfg_prio,
    input  logic [31:0]        cfg_vector,
    output logic               signal_interrupt,
    output logic [31:0]        interrupt_PC,
    input  logic               int_accepted,
    input  logic               interrupt_serviced,
    output logic [ID_W-1:0]    active_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    localparam logic [ID_W:0] SEL_LIMIT = (ID_W + 1)'(NUM_SRC);

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0]                  pending_q;
    logic [NUM_SRC-1:0]                  pending_d;
    logic [NUM_SRC-1:0]                  elig;
    logic [NUM_SRC-1:0][PRIO_W-1:0]      prio_vec;
    intr_cfg_t                           cfg_q [NUM_SRC];
    intr_cfg_t                           cfg_new;

    intr_state_t     state_q, state_d;
    logic            sig_q, sig_d;
    logic            svc_q, svc_d;
    logic [31:0]     pc_q, pc_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            arb_valid;
    logic [ID_W-1:0] arb_id;
    logic            accept;

    assign accept = (state_q == INTR_REQ) && int_accepted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            pending_q <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_src};
            pending_q <= pending_d;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_chan
        if (EDGE_MASK[i]) begin : g_edge
            logic lvl_q, prev_q;
            logic clr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lvl_q  <= 1'b0;
                    prev_q <= 1'b0;
                end else begin
                    lvl_q  <= sync_q[SYNC_STAGES-1][i];
                    prev_q <= lvl_q;
                end
            end

            // A fresh edge in the accept cycle survives the clear.
            assign clr          = accept && (id_q == ID_W'(i));
            assign pending_d[i] = (lvl_q & ~prev_q) | (pending_q[i] & ~clr);
        end else begin : g_level
            assign pending_d[i] = sync_q[SYNC_STAGES-1][i];
        end

        assign elig[i]     = pending_q[i] & cfg_q[i].en & (cfg_q[i].prio != '0);
        assign prio_vec[i] = cfg_q[i].prio[PRIO_W-1:0];
    end

    always_comb begin
        cfg_new                  = '0;
        cfg_new.en               = cfg_en;
        cfg_new.prio[PRIO_W-1:0] = cfg_prio;
        cfg_new.vector           = cfg_vector & VEC_ALIGN_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cfg_q[i] <= '0;
            end
        end else if (cfg_we && ({1'b0, cfg_sel} < SEL_LIMIT)) begin
            cfg_q[cfg_sel] <= cfg_new;
        end
    end

    intr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arb (
        .req    (elig),
        .prio   (prio_vec),
        .valid  (arb_valid),
        .win_id (arb_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INTR_IDLE;
            sig_q   <= 1'b0;
            svc_q   <= 1'b0;
            pc_q    <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            svc_q   <= svc_d;
            pc_q    <= pc_d;
            id_q    <= id_d;
        end
    end

    // Request outputs are only loaded from IDLE, which freezes them through REQ.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        svc_d   = svc_q;
        pc_d    = pc_q;
        id_d    = id_q;
        case (state_q)
            INTR_IDLE: begin
                if (arb_valid) begin
                    state_d = INTR_REQ;
                    sig_d   = 1'b1;
                    id_d    = arb_id;
                    pc_d    = cfg_q[arb_id].vector;
                end
            end
            INTR_REQ: begin
                if (int_accepted) begin
                    state_d = INTR_SERVICE;
                    sig_d   = 1'b0;
                    svc_d   = 1'b1;
                end
            end
            INTR_SERVICE: begin
                if (interrupt_serviced) begin
                    state_d = INTR_IDLE;
                    svc_d   = 1'b0;
                end
            end
            default: begin
                state_d = INTR_IDLE;
            end
        endcase
    end

    assign signal_interrupt = sig_q;
    assign interrupt_PC     = pc_q;
    assign active_id        = id_q;
    assign in_service       = svc_q;
    assign pending          = pending_q;

endmodule

`default_nettype wire
